// File: rtl/dec_lut_encoder28bits_clk.sv
// Sequential binary-to-BCD encoder (shift-add-3 / double-dabble).
// A conversion takes N_BITS shift cycles after the accepting edge. The
// result W is loaded on the last shift edge. A one-cycle registered done
// pulse marks each new W.
//
// Handshake: start is sampled only while the FSM is IDLE (busy=0). The edge
// that sees start=1 also captures N. While busy=1, start and N are ignored
// and nothing is queued. done is high for exactly one cycle per conversion.
// A start in that done cycle is accepted, so back-to-back conversions run
// at one result per N_BITS+1 cycles.
module dec_lut_encoder28bits_clk #(
    parameter int N_BITS = 28,
    parameter int DIGITS = 11,
    parameter int W_BITS = 4 * DIGITS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_BITS-1:0] N,
    output logic              busy,
    output logic              done,
    output logic [W_BITS-1:0] W,
    output logic              state
);

    // Enough bits to count from 0 up to N_BITS shifts.
    localparam int CW = $clog2(N_BITS + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [W_BITS-1:0] acc;
    logic [W_BITS-1:0] acc_adj;
    logic [W_BITS-1:0] acc_next;
    logic [N_BITS-1:0] bin;
    logic [CW-1:0]     cnt;
    logic              last_shift;

    // This edge performs shift number N_BITS (the counter still holds N_BITS-1).
    assign last_shift = (cnt == CW'(N_BITS - 1));

    // Add 3 to every BCD digit of 5 or more, so the next left shift carries into the next digit.
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // The accumulator after the shift takes in the binary register's MSB.
    assign acc_next = {acc_adj[W_BITS-2:0], bin[N_BITS-1]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state logic: IDLE waits for start, SHIFT runs until the last shift.
    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:    if (start)      nxt_state = SHIFT;
            SHIFT:   if (last_shift) nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs decoded from state; state is also exposed for debug.
    always_comb begin
        busy  = (cur_state == SHIFT);
        state = cur_state;
    end

    // Datapath: load on accept, shift-add-3 during SHIFT, publish W and pulse done on the final shift.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc  <= '0;
            bin  <= '0;
            cnt  <= '0;
            W    <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (cur_state)
                IDLE: begin
                    if (start) begin
                        bin <= N;
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                SHIFT: begin
                    acc <= acc_next;
                    bin <= {bin[N_BITS-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                    if (last_shift) begin
                        W    <= acc_next;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_lut_encoder28bits_clk.sv
// Testbench for dec_lut_encoder28bits_clk.
// The reference model builds BCD by repeated division by 10. A decimal
// decoder turns W back into a number for the loopback check.
module tb_dec_lut_encoder28bits_clk;

    localparam int N_BITS = 28;
    localparam int DIGITS = 11;
    localparam int W_BITS = 44;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [N_BITS-1:0] n_in;
    logic              busy;
    logic              done;
    logic [W_BITS-1:0] w_out;
    logic              state_dbg;

    int checks = 0;
    int errors = 0;

    dec_lut_encoder28bits_clk #(
        .N_BITS(N_BITS),
        .DIGITS(DIGITS),
        .W_BITS(W_BITS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .N    (n_in),
        .busy (busy),
        .done (done),
        .W    (w_out),
        .state(state_dbg)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every comparison and report any mismatch.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: decimal digits via repeated division by 10.
    function automatic logic [W_BITS-1:0] bcd_model(input longint unsigned v);
        logic [W_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Loopback decoder: weighted sum of decimal digits; flags any non-decimal digit.
    function automatic longint unsigned bcd_decode(input logic [W_BITS-1:0] w, output bit bad);
        longint unsigned sum;
        longint unsigned weight;
        sum = 0;
        weight = 1;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] > 4'd9) bad = 1'b1;
            sum += longint'(w[4*i +: 4]) * weight;
            weight *= 10;
        end
        return sum;
    endfunction

    // Driver: called at a negedge. It raises start with value n for one edge
    // and then scrambles N during SHIFT. If inj_at >= 0 it pulses start with
    // N=1 after that many shifts. It returns at the negedge where done=1 and
    // checks latency, busy and W.
    task automatic convert(input logic [N_BITS-1:0] n, input int inj_at, input string tag);
        int j;
        start = 1'b1;
        n_in  = n;
        @(negedge clk);
        start = 1'b0;
        n_in  = N_BITS'($urandom);
        j = 0;
        check({tag, "_busy_start"}, 64'(busy), 64'd1);
        while (!done && j < N_BITS + 8) begin
            if (j == inj_at) begin
                start = 1'b1;
                n_in  = 1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            j++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(j), 64'(N_BITS));
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        check({tag, "_w"}, 64'(w_out), 64'(bcd_model(64'(n))));
    endtask

    // Count done pulses over a window, with start held low.
    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    // Scoreboard of expected results for the back-to-back pair.
    logic [W_BITS-1:0] exp_q[$];

    initial begin
        int pulses;
        bit bad;
        logic [N_BITS-1:0] rn;
        longint unsigned dec;
        logic [W_BITS-1:0] held;

        rst_n = 1'b0;
        start = 1'b1;           // start during reset must be ignored
        n_in  = 28'd777;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_w", 64'(w_out), 64'd0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("start_in_reset_ignored", 64'(busy), 64'd0);

        // Zero input.
        convert(28'd0, -1, "zero");
        @(negedge clk);
        check("zero_done_one_cycle", 64'(done), 64'd0);

        // Maximum input.
        convert(28'd268435455, -1, "max");
        check("max_top_digits", 64'(w_out[43:36]), 64'd0);
        @(negedge clk);
        check("max_done_one_cycle", 64'(done), 64'd0);
        held = w_out;
        repeat (5) @(negedge clk);
        check("idle_w_hold", 64'(w_out), 64'(held));

        // Back-to-back: the second start lands in the done cycle.
        exp_q.push_back(44'h9);
        exp_q.push_back(44'h10);
        convert(28'd9, -1, "b2b_first");
        check("b2b_first_q", 64'(w_out), 64'(exp_q.pop_front()));
        convert(28'd10, -1, "b2b_second");
        check("b2b_second_q", 64'(w_out), 64'(exp_q.pop_front()));

        // A start during SHIFT is dropped.
        @(negedge clk);
        convert(28'd12345678, 5, "drop");
        check("drop_w_const", 64'(w_out), 64'h12345678);
        count_done(40, pulses);
        check("drop_no_second_done", 64'(pulses), 64'd0);
        check("drop_w_kept", 64'(w_out), 64'h12345678);

        // Reset partway through a conversion aborts it.
        start = 1'b1;
        n_in  = 28'd99999999;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_w", 64'(w_out), 64'd0);
        count_done(40, pulses);
        check("abort_no_done", 64'(pulses), 64'd0);
        convert(28'd99999999, -1, "restart");

        // Random loopback through the decimal decoder.
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            rn = N_BITS'($urandom);
            if (k % 4 == 0) rn = N_BITS'($urandom_range(0, 9999));
            convert(rn, -1, "rand");
            dec = bcd_decode(w_out, bad);
            check("loop_digits_valid", 64'(bad), 64'd0);
            check("loop_decode", 64'(dec), 64'(rn));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_lut_encoder28bits_clk.md
DEC_LUT_ENCODER28BITS_CLK -- requirements
Module: dec_lut_encoder28bits_clk

Interface
REQ-001 SHALL have parameter N_BITS, default 28, binary input width.
REQ-002 SHALL have parameter DIGITS, default 11, number of BCD output digits.
REQ-003 SHALL have parameter W_BITS, default 44 (4*DIGITS), BCD output width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  request; sampled high in IDLE launches one conversion.
REQ-007 N  input  N_BITS  unsigned binary value; sampled only on the accepting edge.
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse marking a new valid W.
REQ-010 W  output  W_BITS  packed BCD result; digit i in W[4i+3:4i], digit 0 least significant.

Function
REQ-011 SHALL implement a sequential shift-add-3 (double-dabble) binary-to-BCD encoder, the inverse of the team's 28-bit decoder (W -> N).
REQ-012 SHALL use an FSM with states IDLE and SHIFT only; done SHALL be a registered flag, not a state.
REQ-013 IDLE: on an edge with start=1, SHALL load N into the binary shift register, clear the BCD accumulator, clear the shift counter, set busy=1, and go to SHIFT.
REQ-014 IDLE with start=0: SHALL hold all registers; W SHALL keep its last value.
REQ-015 SHIFT, every edge: each accumulator digit >=5 SHALL get +3 first; then {accumulator, binary register} SHALL shift left by 1; the counter SHALL increment.
REQ-016 SHALL perform exactly N_BITS shifts per conversion; counter width SHALL be ceil(log2(N_BITS+1)) bits.
REQ-017 On the edge performing shift N_BITS, W SHALL load the post-shift accumulator, done SHALL go 1, busy SHALL go 0, and the state SHALL return to IDLE.
REQ-018 Latency: start accepted at edge k -> done=1 and W valid in the cycle after edge k+N_BITS (28 cycles for the default).
REQ-019 done SHALL be high for exactly one cycle per conversion and SHALL deassert on the following edge.
REQ-020 start while busy=1 SHALL be ignored; no queuing; N changes during SHIFT SHALL not affect the result.
REQ-021 start=1 in the cycle where done=1 (state IDLE) SHALL be accepted; back-to-back throughput is one result per N_BITS+1 cycles.
REQ-022 Every accumulator digit SHALL stay in 0..9; since 2^28-1 has 9 digits, the top two digits of W SHALL always be 0 at default parameters; no overflow path exists.
REQ-023 W SHALL change only on the completion edge (REQ-017) or on reset.

Reset
REQ-024 rst_n=0 at any edge SHALL force state=IDLE, busy=0, done=0, W=0, accumulator=0, binary register=0, counter=0.
REQ-025 Reset during SHIFT SHALL abort the conversion with no done pulse; the first start after rst_n returns high SHALL begin a fresh conversion.
REQ-026 start sampled at an edge where rst_n=0 SHALL be ignored.

Verification
REQ-027 N=0, start pulse -> done after 28 cycles, W=44'h00000000000.
REQ-028 N=268435455 (max) -> W=44'h00268435455, done exactly one cycle, busy low in the same cycle.
REQ-029 N=9, then N=10 back-to-back (second start in done cycle) -> W=44'h9, then W=44'h10 exactly 29 cycles later.
REQ-030 start with N=12345678; start with N=1 pulsed at cycle 5 of SHIFT -> single done, W=44'h12345678, second request dropped.
REQ-031 rst_n low at shift 14 of N=99999999 -> no done, W=0, busy=0; restart with N=99999999 -> W=44'h99999999.
REQ-032 Loopback: 1000 random N fed through this block then the team's 28-bit decoder -> decoded N equals original N in every case.
